// File: rtl/dat_sched_pkg.sv
// Shared types and defaults for the SD DAT transfer scheduler.
package dat_sched_pkg;

  localparam int BLK_W_DEF     = 4;
  localparam int TMO_W_DEF     = 16;
  localparam int MAX_RETRY_DEF = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_ACK   = 3'd3,
    S_ABORT = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

  // On a tie the requester that did not win last time gets the grant.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (last_grant == REQ1) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/dat_sched_rr_arb.sv
// Two-way round-robin picker; last_grant resets to requester 1 so requester 0 wins the first tie.
module dat_sched_rr_arb
  import dat_sched_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic       last_grant_r;
  logic [1:0] pick_s;

  // One-hot grant, only offered while the scheduler can accept a descriptor.
  always_comb begin
    pick_s = rr_pick(req, last_grant_r);
    if (enable) begin
      grant = pick_s;
    end else begin
      grant = 2'b00;
    end
  end

  // Remember the winner of each accepted grant.
  always_ff @(posedge sd_clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= REQ1;
    end else if (grant != 2'b00) begin
      last_grant_r <= grant[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/dat_xfer_scheduler.sv
// Round-robin DAT transfer scheduler: latches a descriptor, strobes the DAT PHY, closes ack/abort.
// Optional timeout retry is compiled in with `define DAT_SCHED_RETRY_EN.
module dat_xfer_scheduler
  import dat_sched_pkg::*;
#(
  parameter int BLK_W     = BLK_W_DEF,
  parameter int TMO_W     = TMO_W_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic               sd_clock,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_write,
  input  logic [1:0]         req_multiple,
  input  logic [2*BLK_W-1:0] req_blocks,
  output logic [1:0]         req_grant,
  output logic [1:0]         req_done,
  output logic [1:0]         req_error,
  output logic               busy,
  input  logic [TMO_W-1:0]   timeout_value,
  input  logic               phy_serial_ready,
  input  logic               phy_complete,
  input  logic               phy_ack_out,
  input  logic               phy_timeout,
  output logic               phy_strobe,
  output logic               phy_write_read,
  output logic               phy_multiple,
  output logic [BLK_W-1:0]   phy_blocks,
  output logic [TMO_W-1:0]   phy_timeout_reg,
  output logic               phy_ack,
  output logic               phy_idle
);

  state_e     state_r;
  logic [1:0] granted_r;
  logic [1:0] grant_s;
  logic       arb_en_s;

`ifdef DAT_SCHED_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_cnt_r;
`endif

  assign arb_en_s = (state_r == S_IDLE) && phy_serial_ready;

  dat_sched_rr_arb u_arb (
    .sd_clock (sd_clock),
    .reset_n  (reset_n),
    .req      (req_valid),
    .enable   (arb_en_s),
    .grant    (grant_s)
  );

  // Transfer FSM with registered handshake pulses and descriptor capture.
  always_ff @(posedge sd_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= S_IDLE;
      granted_r       <= 2'b00;
      req_grant       <= 2'b00;
      req_done        <= 2'b00;
      req_error       <= 2'b00;
      busy            <= 1'b0;
      phy_strobe      <= 1'b0;
      phy_write_read  <= 1'b0;
      phy_multiple    <= 1'b0;
      phy_blocks      <= '0;
      phy_timeout_reg <= '0;
      phy_ack         <= 1'b0;
      phy_idle        <= 1'b0;
`ifdef DAT_SCHED_RETRY_EN
      retry_cnt_r     <= '0;
`endif
    end else begin
      req_grant  <= 2'b00;
      req_done   <= 2'b00;
      req_error  <= 2'b00;
      phy_strobe <= 1'b0;
      phy_idle   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (grant_s != 2'b00) begin
            state_r         <= S_ISSUE;
            busy            <= 1'b1;
            req_grant       <= grant_s;
            granted_r       <= grant_s;
            phy_timeout_reg <= timeout_value;
`ifdef DAT_SCHED_RETRY_EN
            retry_cnt_r     <= '0;
`endif
            if (grant_s[1]) begin
              phy_write_read <= req_write[1];
              phy_multiple   <= req_multiple[1];
              phy_blocks     <= req_blocks[2*BLK_W-1:BLK_W];
            end else begin
              phy_write_read <= req_write[0];
              phy_multiple   <= req_multiple[0];
              phy_blocks     <= req_blocks[BLK_W-1:0];
            end
          end
        end
        S_ISSUE: begin
          phy_strobe <= 1'b1;
          state_r    <= S_BUSY;
        end
        S_BUSY: begin
          // Completion takes precedence over a coincident timeout.
          if (phy_complete) begin
            phy_ack <= 1'b1;
            state_r <= S_ACK;
          end else if (phy_timeout) begin
            phy_idle <= 1'b1;
            state_r  <= S_ABORT;
          end
        end
        S_ACK: begin
          if (phy_ack_out) begin
            phy_ack  <= 1'b0;
            req_done <= granted_r;
            busy     <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        S_ABORT: begin
          state_r <= S_DRAIN;
        end
        S_DRAIN: begin
          if (phy_serial_ready) begin
`ifdef DAT_SCHED_RETRY_EN
            if (retry_cnt_r < RETRY_LIMIT) begin
              retry_cnt_r <= retry_cnt_r + RETRY_W'(1);
              state_r     <= S_ISSUE;
            end else begin
              req_error <= granted_r;
              busy      <= 1'b0;
              state_r   <= S_IDLE;
            end
`else
            req_error <= granted_r;
            busy      <= 1'b0;
            state_r   <= S_IDLE;
`endif
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          phy_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dat_xfer_scheduler.sv
// Self-checking bench for dat_xfer_scheduler: directed cases plus randomized transfers vs a rule-level model.
module tb_dat_xfer_scheduler;

  localparam int BLK_W     = 4;
  localparam int TMO_W     = 16;
  localparam int MAX_RETRY = 2;
`ifdef DAT_SCHED_RETRY_EN
  localparam int N_TRIES = MAX_RETRY + 1;
`else
  localparam int N_TRIES = 1;
`endif

  logic               sd_clock;
  logic               reset_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_write;
  logic [1:0]         req_multiple;
  logic [2*BLK_W-1:0] req_blocks;
  logic [1:0]         req_grant;
  logic [1:0]         req_done;
  logic [1:0]         req_error;
  logic               busy;
  logic [TMO_W-1:0]   timeout_value;
  logic               phy_serial_ready;
  logic               phy_complete;
  logic               phy_ack_out;
  logic               phy_timeout;
  logic               phy_strobe;
  logic               phy_write_read;
  logic               phy_multiple;
  logic [BLK_W-1:0]   phy_blocks;
  logic [TMO_W-1:0]   phy_timeout_reg;
  logic               phy_ack;
  logic               phy_idle;

  int total = 0;
  int bad   = 0;
  int last_m = 1;
  int strobe_cnt = 0;
  int grant_cnt  = 0;

  dat_xfer_scheduler #(.BLK_W(BLK_W), .TMO_W(TMO_W), .MAX_RETRY(MAX_RETRY)) dut (
    .sd_clock         (sd_clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_multiple     (req_multiple),
    .req_blocks       (req_blocks),
    .req_grant        (req_grant),
    .req_done         (req_done),
    .req_error        (req_error),
    .busy             (busy),
    .timeout_value    (timeout_value),
    .phy_serial_ready (phy_serial_ready),
    .phy_complete     (phy_complete),
    .phy_ack_out      (phy_ack_out),
    .phy_timeout      (phy_timeout),
    .phy_strobe       (phy_strobe),
    .phy_write_read   (phy_write_read),
    .phy_multiple     (phy_multiple),
    .phy_blocks       (phy_blocks),
    .phy_timeout_reg  (phy_timeout_reg),
    .phy_ack          (phy_ack),
    .phy_idle         (phy_idle)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sd_clock);
    #1;
    if (phy_strobe === 1'b1) strobe_cnt++;
    if (req_grant !== 2'b00) grant_cnt++;
  endtask

  // Round-robin rule: a lone requester wins; a tie goes to the one not granted last.
  function automatic int pick(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return (last_m == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] all_outs();
    return {req_grant, req_done, req_error, busy, phy_strobe, phy_write_read,
            phy_multiple, phy_blocks, phy_timeout_reg, phy_ack, phy_idle};
  endfunction

  function automatic logic [31:0] quiet_vec();
    return {23'd0, req_grant, req_done, req_error, phy_ack, phy_idle, phy_strobe};
  endfunction

  // outcome: 0 = complete, 1 = timeout (every attempt), 2 = complete and timeout together
  task automatic do_xfer(input logic [1:0] valid, input logic [1:0] wr, input logic [1:0] mult,
                         input logic [7:0] blks, input logic [15:0] tmo,
                         input int outcome, input int wait_cyc);
    int w;
    int tries;
    int g0;
    int s0;
    logic [1:0] oh;
    logic [3:0] eb;
    logic       edir;
    logic       emul;
    w     = pick(valid);
    oh    = (w == 0) ? 2'b01 : 2'b10;
    eb    = (w == 0) ? blks[3:0] : blks[7:4];
    edir  = wr[w];
    emul  = mult[w];
    last_m = w;
    g0 = grant_cnt;
    s0 = strobe_cnt;

    req_valid = valid; req_write = wr; req_multiple = mult;
    req_blocks = blks; timeout_value = tmo; phy_serial_ready = 1'b1;
    step();
    chk("grant", {30'd0, req_grant}, {30'd0, oh});
    chk("busy_on", {31'd0, busy}, 32'd1);
    chk("strobe_early", {31'd0, phy_strobe}, 32'd0);
    chk("blocks", {28'd0, phy_blocks}, {28'd0, eb});
    chk("dir", {31'd0, phy_write_read}, {31'd0, edir});
    chk("mult", {31'd0, phy_multiple}, {31'd0, emul});
    chk("tmo", {16'd0, phy_timeout_reg}, {16'd0, tmo});
    // Disturb the request side; the latched descriptor must not follow.
    req_valid = 2'b00;
    req_blocks = 8'($urandom);
    req_write = 2'($urandom);
    req_multiple = 2'($urandom);
    timeout_value = 16'($urandom);
    phy_serial_ready = 1'($urandom);

    tries = (outcome == 1) ? N_TRIES : 1;
    for (int t = 0; t < tries; t++) begin
      step();
      chk("strobe", {31'd0, phy_strobe}, 32'd1);
      chk("grant_once", {30'd0, req_grant}, 32'd0);
      for (int c = 0; c < wait_cyc; c++) begin
        step();
        chk("busy_quiet", quiet_vec(), 32'd0);
        chk("hold_desc", {phy_timeout_reg, 10'd0, phy_write_read, phy_multiple, phy_blocks},
                         {tmo, 10'd0, edir, emul, eb});
      end
      if (outcome == 1) begin
        phy_timeout = 1'b1; phy_serial_ready = 1'b0;
        step();
        chk("idle_pulse", {31'd0, phy_idle}, 32'd1);
        phy_timeout = 1'b0;
        step();
        chk("idle_end", {31'd0, phy_idle}, 32'd0);
        for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
          step();
          chk("drain_quiet", quiet_vec(), 32'd0);
        end
        phy_serial_ready = 1'b1;
        step();
        if (t < tries - 1) chk("retry_no_err", {28'd0, req_error, req_done}, 32'd0);
      end
    end

    if (outcome == 1) begin
      chk("error", {30'd0, req_error}, {30'd0, oh});
      chk("no_done", {30'd0, req_done}, 32'd0);
      chk("busy_off_err", {31'd0, busy}, 32'd0);
      chk("strobe_count", strobe_cnt - s0, N_TRIES);
    end else begin
      phy_complete = 1'b1;
      phy_timeout  = (outcome == 2);
      step();
      chk("ack", {31'd0, phy_ack}, 32'd1);
      chk("no_idle", {31'd0, phy_idle}, 32'd0);
      phy_timeout = 1'b0;
      req_valid = 2'b11;
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        step();
        chk("ack_hold", {30'd0, phy_ack, req_done != 2'b00}, 32'd2);
      end
      phy_ack_out = 1'b1; phy_serial_ready = 1'b1;
      step();
      chk("done", {30'd0, req_done}, {30'd0, oh});
      chk("ack_drop", {31'd0, phy_ack}, 32'd0);
      chk("no_grant_at_done", {30'd0, req_grant}, 32'd0);
      chk("no_err", {30'd0, req_error}, 32'd0);
      chk("busy_off", {31'd0, busy}, 32'd0);
      phy_complete = 1'b0; phy_ack_out = 1'b0; req_valid = 2'b00;
    end
    chk("grant_count", grant_cnt - g0, 1);
    step();
    chk("pulses_end", quiet_vec(), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00; req_write = 2'b00; req_multiple = 2'b00; req_blocks = '0;
    timeout_value = '0; phy_serial_ready = 1'b0; phy_complete = 1'b0;
    phy_ack_out = 1'b0; phy_timeout = 1'b0;
    repeat (3) @(posedge sd_clock);
    #1;
    chk("reset_outs", all_outs(), 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_outs", all_outs(), 32'd0);

    // Three ties in a row alternate starting at requester 0.
    do_xfer(2'b11, 2'b10, 2'b01, 8'h72, 16'h0100, 0, 1);
    do_xfer(2'b11, 2'b10, 2'b01, 8'h72, 16'h0101, 0, 2);
    do_xfer(2'b11, 2'b01, 2'b10, 8'h9A, 16'h0102, 0, 0);
    // Single multi-block write from requester 0, three blocks.
    do_xfer(2'b01, 2'b01, 2'b01, 8'h03, 16'hBEEF, 0, 3);
    // Read that times out after about 20 cycles.
    do_xfer(2'b01, 2'b00, 2'b00, 8'h05, 16'h1234, 1, 18);
    // Completion and timeout together.
    do_xfer(2'b10, 2'b10, 2'b00, 8'h40, 16'h00FF, 2, 2);
    // Zero block count is passed through.
    do_xfer(2'b10, 2'b00, 2'b10, 8'h0F, 16'h0001, 0, 1);

    for (int i = 0; i < 12; i++) begin
      do_xfer(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 8'($urandom),
              16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
    end

    // Reset in the middle of a transfer.
    req_valid = 2'b01; req_write = 2'b01; req_multiple = 2'b01;
    req_blocks = 8'h0C; timeout_value = 16'hAAAA; phy_serial_ready = 1'b1;
    step();
    req_valid = 2'b00;
    step();
    step();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(), 32'd0);
    step();
    reset_n = 1'b1;
    last_m = 1;
    step();
    chk("post_reset_outs", all_outs(), 32'd0);
    do_xfer(2'b10, 2'b10, 2'b10, 8'h6E, 16'h5555, 0, 1);
    do_xfer(2'b11, 2'b00, 2'b00, 8'h21, 16'h7777, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
